// File: rtl/router_pkg.sv
// Shared types and header field layout for the router packet transmitter.
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY
  } tx_state_e;

  localparam int LEN_W    = 6;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_W   = 2;
  localparam int ADDR_LSB = 0;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  function automatic logic [7:0] make_header(input logic [LEN_W-1:0]  len,
                                             input logic [ADDR_W-1:0] addr);
    logic [7:0] h;
    h = '0;
    h[LEN_LSB +: LEN_W]   = len;
    h[ADDR_LSB +: ADDR_W] = addr;
    return h;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload staging buffer: synchronous write while collecting, combinational read while sending.
module router_tx_buf #(
  parameter int DEPTH = 63,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Host-to-router packet transmitter: buffers a payload, then sends header, payload and parity.
// Optional ROUTER_TX_PARITY_ERR_INJ_EN adds tx_err_inj to corrupt parity bit 0 for test.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN = 63
) (
  input  logic       router_clock,
  input  logic       router_reset,
  input  logic       tx_start,
  input  logic [1:0] tx_addr,
  input  logic [5:0] tx_len,
  output logic       tx_ready,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       pkt_valid,
  output logic [7:0] data_in,
  output logic       tx_done,
  output logic       tx_abort,
  output logic       req_err
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
  ,
  input  logic       tx_err_inj
`endif
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [6:0] MAX_LEN_V = 7'(MAX_LEN);

  tx_state_e   state_q, state_d;
  logic [1:0]  addr_q, addr_d;
  logic [5:0]  len_q, len_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  par_q, par_d;
  logic        inj_q, inj_d;

  logic        tx_ready_q, tx_ready_d;
  logic        pl_ready_q, pl_ready_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic [7:0]  data_q, data_d;
  logic        tx_done_q, tx_done_d;
  logic        tx_abort_q, tx_abort_d;
  logic        req_err_q, req_err_d;

  logic        wr_en;
  logic [7:0]  rd_data;
  logic [7:0]  header;
  logic        req_bad;
  logic        last_byte;
  logic        abort_hit;
  logic [3:0]  soft_rst_vec;

  router_tx_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (router_clock),
    .wr_en   (wr_en),
    .wr_addr (cnt_q[AW-1:0]),
    .wr_data (pl_data),
    .rd_addr (cnt_d[AW-1:0]),
    .rd_data (rd_data)
  );

  assign header       = make_header(len_q, addr_q);
  assign req_bad      = (tx_addr == ADDR_INVALID) || (tx_len == '0) || ({1'b0, tx_len} > MAX_LEN_V);
  assign last_byte    = (cnt_q == (len_q - 6'd1));
  // Index 3 is the invalid address and never matches a soft reset.
  assign soft_rst_vec = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign abort_hit    = soft_rst_vec[addr_q];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    inj_d      = inj_q;
    req_err_d  = 1'b0;
    tx_done_d  = 1'b0;
    tx_abort_d = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          if (req_bad) begin
            req_err_d = 1'b1;
          end else begin
            addr_d  = tx_addr;
            len_d   = tx_len;
            cnt_d   = '0;
            par_d   = '0;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
            inj_d   = tx_err_inj;
`else
            inj_d   = 1'b0;
`endif
            state_d = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (pl_valid) begin
          wr_en = 1'b1;
          par_d = par_q ^ pl_data;
          cnt_d = cnt_q + 6'd1;
          if (last_byte) state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (abort_hit) begin
          state_d    = ST_IDLE;
          tx_abort_d = 1'b1;
        end else if (!busy) begin
          par_d   = par_q ^ header;
          cnt_d   = '0;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (abort_hit) begin
          state_d    = ST_IDLE;
          tx_abort_d = 1'b1;
        end else if (!busy) begin
          if (last_byte) state_d = ST_PARITY;
          else           cnt_d   = cnt_q + 6'd1;
        end
      end
      ST_PARITY: begin
        if (abort_hit) begin
          state_d    = ST_IDLE;
          tx_abort_d = 1'b1;
        end else if (!busy) begin
          state_d   = ST_IDLE;
          tx_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so busy never reaches a port combinationally.
  always_comb begin
    tx_ready_d  = (state_d == ST_IDLE);
    pl_ready_d  = (state_d == ST_COLLECT);
    pkt_valid_d = (state_d == ST_HEADER) || (state_d == ST_PAYLOAD);
    data_d      = 8'h00;
    case (state_d)
      ST_HEADER:  data_d = header;
      ST_PAYLOAD: data_d = rd_data;
      ST_PARITY:  data_d = par_d ^ {7'b0, inj_d};
      default:    data_d = 8'h00;
    endcase
  end

  always_ff @(posedge router_clock) begin
    if (router_reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      par_q       <= '0;
      inj_q       <= 1'b0;
      tx_ready_q  <= 1'b1;
      pl_ready_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      data_q      <= 8'h00;
      tx_done_q   <= 1'b0;
      tx_abort_q  <= 1'b0;
      req_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      inj_q       <= inj_d;
      tx_ready_q  <= tx_ready_d;
      pl_ready_q  <= pl_ready_d;
      pkt_valid_q <= pkt_valid_d;
      data_q      <= data_d;
      tx_done_q   <= tx_done_d;
      tx_abort_q  <= tx_abort_d;
      req_err_q   <= req_err_d;
    end
  end

  assign tx_ready  = tx_ready_q;
  assign pl_ready  = pl_ready_q;
  assign pkt_valid = pkt_valid_q;
  assign data_in   = data_q;
  assign tx_done   = tx_done_q;
  assign tx_abort  = tx_abort_q;
  assign req_err   = req_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx (ROUTER_TX_PARITY_ERR_INJ_EN aware).
module tb_router_pkt_tx;

  typedef logic [7:0] bq_t [$];

  logic       router_clock = 1'b0;
  logic       router_reset = 1'b1;
  logic       tx_start     = 1'b0;
  logic [1:0] tx_addr      = '0;
  logic [5:0] tx_len       = '0;
  logic       tx_ready;
  logic [7:0] pl_data      = '0;
  logic       pl_valid     = 1'b0;
  logic       pl_ready;
  logic       busy         = 1'b0;
  logic       soft_reset_0 = 1'b0;
  logic       soft_reset_1 = 1'b0;
  logic       soft_reset_2 = 1'b0;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       tx_done;
  logic       tx_abort;
  logic       req_err;
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
  logic       tx_err_inj   = 1'b0;
  localparam logic [7:0] PAR_BASIC = 8'h0C;
`else
  localparam logic [7:0] PAR_BASIC = 8'h0D;
`endif

  int checks   = 0;
  int failures = 0;

  router_pkt_tx #(.MAX_LEN(63)) dut (
    .router_clock (router_clock),
    .router_reset (router_reset),
    .tx_start     (tx_start),
    .tx_addr      (tx_addr),
    .tx_len       (tx_len),
    .tx_ready     (tx_ready),
    .pl_data      (pl_data),
    .pl_valid     (pl_valid),
    .pl_ready     (pl_ready),
    .busy         (busy),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .tx_done      (tx_done),
    .tx_abort     (tx_abort),
    .req_err      (req_err)
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    ,
    .tx_err_inj   (tx_err_inj)
`endif
  );

  always #5 router_clock = ~router_clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge router_clock);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_tx_ready"}, tx_ready, 1'b1);
    chk1({tag, "_pl_ready"}, pl_ready, 1'b0);
    chk1({tag, "_pkt_valid"}, pkt_valid, 1'b0);
    chk8({tag, "_data_in"}, data_in, 8'h00);
    chk1({tag, "_tx_done"}, tx_done, 1'b0);
    chk1({tag, "_tx_abort"}, tx_abort, 1'b0);
    chk1({tag, "_req_err"}, req_err, 1'b0);
  endtask

  task automatic start_pkt(input logic [1:0] a, input logic [5:0] l);
    tx_start = 1'b1;
    tx_addr  = a;
    tx_len   = l;
    tick();
    tx_start = 1'b0;
  endtask

  // Feeds payload bytes; with gap set, pl_valid is low every other cycle.
  task automatic collect(input string tag, input bq_t b, input bit gap);
    chk1({tag, "_collect_pl_ready"}, pl_ready, 1'b1);
    chk1({tag, "_collect_tx_ready"}, tx_ready, 1'b0);
    for (int i = 0; i < b.size(); i++) begin
      if (gap) begin
        pl_valid = 1'b0;
        tick();
      end
      chk1($sformatf("%s_collect_pkt_valid[%0d]", tag, i), pkt_valid, 1'b0);
      pl_valid = 1'b1;
      pl_data  = b[i];
      tick();
    end
    pl_valid = 1'b0;
    chk1({tag, "_collect_done_pl_ready"}, pl_ready, 1'b0);
  endtask

  // Walks the router-side byte sequence, stalling with busy at up to two byte indices.
  task automatic router_side(input string tag, input bq_t exp,
                             input int s1_idx, input int s1_n,
                             input int s2_idx, input int s2_n);
    int last;
    int n;
    last = exp.size() - 1;
    for (int k = 0; k <= last; k++) begin
      n = (k == s1_idx) ? s1_n : ((k == s2_idx) ? s2_n : 0);
      for (int c = 0; c <= n; c++) begin
        chk1($sformatf("%s_pkt_valid[%0d.%0d]", tag, k, c), pkt_valid, (k != last));
        chk8($sformatf("%s_data_in[%0d.%0d]", tag, k, c), data_in, exp[k]);
        busy = (c < n);
        tick();
      end
    end
    busy = 1'b0;
    chk1({tag, "_tx_done"}, tx_done, 1'b1);
    chk1({tag, "_end_tx_ready"}, tx_ready, 1'b1);
    chk1({tag, "_end_pkt_valid"}, pkt_valid, 1'b0);
    chk8({tag, "_end_data_in"}, data_in, 8'h00);
    tick();
    chk1({tag, "_tx_done_clear"}, tx_done, 1'b0);
  endtask

  initial begin
    bq_t pl;
    bq_t ex;
    logic [7:0] par;

    // Reset state
    repeat (3) tick();
    router_reset = 1'b0;
    chk_idle("reset");
    tick();
    chk_idle("reset_hold");

    // Basic packet addr=1 len=3
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    tx_err_inj = 1'b1;
`endif
    start_pkt(2'd1, 6'd3);
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    tx_err_inj = 1'b0;
`endif
    pl = {8'h11, 8'h22, 8'h33};
    collect("basic", pl, 1'b0);
    ex = {8'h0D, 8'h11, 8'h22, 8'h33, PAR_BASIC};
    router_side("basic", ex, -1, 0, -1, 0);

    // Same packet with stalls after header transfer and during parity
    start_pkt(2'd1, 6'd3);
    collect("stall", pl, 1'b0);
    ex = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    router_side("stall", ex, 1, 2, 4, 3);

    // Invalid requests
    start_pkt(2'd3, 6'd5);
    chk1("err_addr3_req_err", req_err, 1'b1);
    chk1("err_addr3_tx_ready", tx_ready, 1'b1);
    chk1("err_addr3_pkt_valid", pkt_valid, 1'b0);
    tick();
    chk1("err_addr3_clear", req_err, 1'b0);
    start_pkt(2'd0, 6'd0);
    chk1("err_len0_req_err", req_err, 1'b1);
    chk1("err_len0_tx_ready", tx_ready, 1'b1);
    chk1("err_len0_pl_ready", pl_ready, 1'b0);
    tick();
    chk_idle("err_len0_after");

    // Maximum length with gapped payload
    pl = {};
    par = 8'hFE;
    for (int i = 0; i < 63; i++) begin
      pl.push_back(8'(i * 37 + 5));
      par = par ^ 8'(i * 37 + 5);
    end
    start_pkt(2'd2, 6'd63);
    collect("maxlen", pl, 1'b1);
    ex = {8'hFE};
    for (int i = 0; i < 63; i++) ex.push_back(pl[i]);
    ex.push_back(par);
    router_side("maxlen", ex, -1, 0, -1, 0);

    // Matching soft reset aborts mid-payload
    pl = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    start_pkt(2'd2, 6'd4);
    collect("abort", pl, 1'b0);
    chk8("abort_header", data_in, 8'h12);
    tick();
    chk8("abort_pl0", data_in, 8'hA1);
    tick();
    chk8("abort_pl1", data_in, 8'hB2);
    soft_reset_2 = 1'b1;
    tick();
    soft_reset_2 = 1'b0;
    chk1("abort_tx_abort", tx_abort, 1'b1);
    chk1("abort_pkt_valid", pkt_valid, 1'b0);
    chk8("abort_data_in", data_in, 8'h00);
    chk1("abort_tx_ready", tx_ready, 1'b1);
    chk1("abort_tx_done", tx_done, 1'b0);
    tick();
    chk1("abort_clear", tx_abort, 1'b0);

    // Non-matching soft reset held throughout is ignored
    soft_reset_0 = 1'b1;
    start_pkt(2'd2, 6'd4);
    collect("sr0", pl, 1'b0);
    ex = {8'h12, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h16};
    router_side("sr0", ex, -1, 0, -1, 0);
    chk1("sr0_no_abort", tx_abort, 1'b0);
    soft_reset_0 = 1'b0;

    // Reset mid-payload, then recovery
    pl = {8'h11, 8'h22, 8'h33};
    start_pkt(2'd1, 6'd3);
    collect("rst", pl, 1'b0);
    tick();
    tick();
    chk8("rst_mid_payload", data_in, 8'h22);
    router_reset = 1'b1;
    tick();
    router_reset = 1'b0;
    chk_idle("rst_after");
    tick();
    chk_idle("rst_after2");
    start_pkt(2'd1, 6'd3);
    collect("recover", pl, 1'b0);
    ex = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    router_side("recover", ex, 0, 1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
